// File: rtl/pokey_dual_counter_if.sv
// Bus bundle for pokey_dual_counter: reload writes, count strobes, mode
// controls and the counter/borrow outputs.
interface pokey_dual_counter_if #(
    parameter int WIDTH = 8
);
    logic             enn_i;
    logic [WIDTH-1:0] din_i;
    logic             wr0_i;
    logic             wr1_i;
    logic             tick0_i;
    logic             tick1_i;
    logic             join_i;
    logic             stimer_i;
    logic [WIDTH-1:0] cnt0_o;
    logic [WIDTH-1:0] cnt1_o;
    logic             bor0_o;
    logic             bor1_o;

    modport master (
        output enn_i, din_i, wr0_i, wr1_i, tick0_i, tick1_i, join_i, stimer_i,
        input  cnt0_o, cnt1_o, bor0_o, bor1_o
    );

    modport slave (
        input  enn_i, din_i, wr0_i, wr1_i, tick0_i, tick1_i, join_i, stimer_i,
        output cnt0_o, cnt1_o, bor0_o, bor1_o
    );
endinterface

// File: rtl/pokey_dual_counter.sv
// Two loadable down-counter channels with reload registers and borrow
// pulses; join cascades them into one 2*WIDTH-bit counter. Falling-edge state.
module pokey_dual_counter #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    pokey_dual_counter_if.slave bus
);
    localparam int CW = 2 * WIDTH;

    logic [1:0][WIDTH-1:0] reload_q, reload_d;
    logic [1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            bor_q, bor_d;
    logic [1:0]            tick;
    logic [1:0]            wr;
    logic [CW-1:0]         cat_cnt;
    logic [CW-1:0]         cat_rel;

    assign tick    = {bus.tick1_i, bus.tick0_i};
    assign wr      = {bus.wr1_i, bus.wr0_i};
    // Channel 1 is the high half when joined.
    assign cat_cnt = cnt_q;
    assign cat_rel = reload_q;

    always_comb begin
        reload_d = reload_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        if (bus.enn_i) begin
            for (int i = 0; i < 2; i++) begin
                if (wr[i]) reload_d[i] = bus.din_i;
            end
            bor_d = '0;
            if (bus.join_i) begin
                // Loads use the pre-write reload value; new writes apply next load.
                if (bus.stimer_i) begin
                    cnt_d = cat_rel;
                end else if (bus.tick0_i) begin
                    if (cat_cnt == '0) begin
                        cnt_d    = cat_rel;
                        bor_d[1] = 1'b1;
                    end else begin
                        cnt_d = cat_cnt - CW'(1);
                    end
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (bus.stimer_i) begin
                        cnt_d[i] = reload_q[i];
                    end else if (tick[i]) begin
                        if (cnt_q[i] == '0) begin
                            cnt_d[i] = reload_q[i];
                            bor_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] - WIDTH'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            reload_q <= '0;
            cnt_q    <= '0;
            bor_q    <= '0;
        end else begin
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
        end
    end

    assign bus.cnt0_o = cnt_q[0];
    assign bus.cnt1_o = cnt_q[1];
    assign bus.bor0_o = bor_q[0];
    assign bus.bor1_o = bor_q[1];
endmodule

// File: tb/tb_pokey_dual_counter.sv
// Directed plus randomized bench for pokey_dual_counter against an
// integer-arithmetic reference model.
module tb_pokey_dual_counter;
    localparam int WIDTH = 8;
    localparam int M     = 1 << WIDTH;

    logic clk = 1'b1;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;
    int   m_r0, m_r1, m_c0, m_c1, m_b0, m_b1;

    pokey_dual_counter_if #(.WIDTH(WIDTH)) bus ();

    pokey_dual_counter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chan(input bit st, input bit tk, input int r, inout int c, output int b);
        b = 0;
        if (st) c = r;
        else if (tk) begin
            if (c == 0) begin
                c = r;
                b = 1;
            end else c = c - 1;
        end
    endtask

    task automatic model_step();
        int n0, n1, cc, rr;
        if (rst) begin
            m_r0 = 0; m_r1 = 0; m_c0 = 0; m_c1 = 0; m_b0 = 0; m_b1 = 0;
        end else if (bus.enn_i) begin
            n0 = bus.wr0_i ? int'(bus.din_i) : m_r0;
            n1 = bus.wr1_i ? int'(bus.din_i) : m_r1;
            if (bus.join_i) begin
                cc = m_c1 * M + m_c0;
                rr = m_r1 * M + m_r0;
                m_b0 = 0;
                chan(bus.stimer_i, bus.tick0_i, rr, cc, m_b1);
                m_c1 = cc / M;
                m_c0 = cc % M;
            end else begin
                chan(bus.stimer_i, bus.tick0_i, m_r0, m_c0, m_b0);
                chan(bus.stimer_i, bus.tick1_i, m_r1, m_c1, m_b1);
            end
            m_r0 = n0;
            m_r1 = n1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        #1;
        chk("cnt0", int'(bus.cnt0_o), m_c0);
        chk("cnt1", int'(bus.cnt1_o), m_c1);
        chk("bor0", int'(bus.bor0_o), m_b0);
        chk("bor1", int'(bus.bor1_o), m_b1);
    endtask

    task automatic idle_in();
        bus.wr0_i = 0; bus.wr1_i = 0; bus.stimer_i = 0;
        bus.tick0_i = 0; bus.tick1_i = 0;
    endtask

    initial begin
        int bcnt, b0cnt;
        rst = 1; bus.enn_i = 0; bus.din_i = 0; bus.join_i = 0;
        idle_in();
        step();
        rst = 0; bus.enn_i = 1;

        // zero reload: borrow on every tick, count stays 0
        bus.tick0_i = 1; bus.tick1_i = 1;
        repeat (4) step();
        chk("idle_bor0", int'(bus.bor0_o), 1);

        // independent channel 0, reload 3 -> period 4
        idle_in(); bus.din_i = 3; bus.wr0_i = 1; step();
        bus.wr0_i = 0; bus.stimer_i = 1; step();
        chk("ind_load", int'(bus.cnt0_o), 3);
        bus.stimer_i = 0; bus.tick0_i = 1;
        repeat (9) step();

        // joined, R = 0x0102 -> one bor1 per 259 ticks
        idle_in(); bus.din_i = 8'h01; bus.wr1_i = 1; step();
        bus.wr1_i = 0; bus.din_i = 8'h02; bus.wr0_i = 1; step();
        bus.wr0_i = 0; bus.join_i = 1; bus.stimer_i = 1; step();
        chk("join_load", int'({bus.cnt1_o, bus.cnt0_o}), 16'h0102);
        bus.stimer_i = 0; bus.tick0_i = 1;
        bcnt = 0; b0cnt = 0;
        for (int k = 0; k < 518; k++) begin
            bus.tick1_i = 1'($urandom);
            step();
            bcnt  += int'(bus.bor1_o);
            b0cnt += int'(bus.bor0_o);
        end
        chk("join_bor1_count", bcnt, 2);
        chk("join_bor0_count", b0cnt, 0);

        // enable gating
        idle_in(); bus.join_i = 0; bus.din_i = 2; bus.wr0_i = 1; step();
        bus.wr0_i = 0; bus.stimer_i = 1; step();
        bus.stimer_i = 0; bus.tick0_i = 1;
        for (int k = 0; k < 12; k++) begin
            bus.enn_i = 1'(k % 2 == 0);
            step();
        end
        bus.enn_i = 1;

        // write + stimer on the same edge loads the old reload (2)
        idle_in(); bus.din_i = 5; bus.wr0_i = 1; bus.stimer_i = 1; step();
        chk("wr_stimer_old", int'(bus.cnt0_o), 2);
        idle_in(); bus.tick0_i = 1;
        repeat (3) step();
        chk("zero_reload_new", int'(bus.cnt0_o), 5);
        repeat (5) step();
        chk("at_zero", int'(bus.cnt0_o), 0);
        bus.stimer_i = 1; step();
        chk("stimer_tick_nobor", int'(bus.bor0_o), 0);
        chk("stimer_tick_load", int'(bus.cnt0_o), 5);

        // reset mid joined count, enn low
        idle_in(); bus.din_i = 8'hFF; bus.wr0_i = 1; bus.wr1_i = 1; step();
        idle_in(); bus.join_i = 1; bus.stimer_i = 1; step();
        bus.stimer_i = 0; bus.tick0_i = 1;
        repeat (3) step();
        rst = 1; bus.enn_i = 0; step();
        chk("rst_cnt", int'({bus.cnt1_o, bus.cnt0_o}), 0);
        rst = 0; bus.enn_i = 1;

        // randomized phase
        for (int k = 0; k < 400; k++) begin
            rst          = ($urandom_range(0, 63) == 0);
            bus.enn_i    = ($urandom_range(0, 7) != 0);
            bus.din_i    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            bus.wr0_i    = ($urandom_range(0, 7) == 0);
            bus.wr1_i    = ($urandom_range(0, 7) == 0);
            bus.stimer_i = ($urandom_range(0, 15) == 0);
            bus.tick0_i  = ($urandom_range(0, 3) != 0);
            bus.tick1_i  = 1'($urandom);
            bus.join_i   = (k / 100) % 2 == 1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pokey_dual_counter.md
# pokey_dual_counter

Parametrised pair of loadable down-counter channels with reload registers, borrow pulses and a join mode that cascades both channels into one 2×WIDTH-bit counter. It generalises the single-bit decrement cell into complete counter channels. It sits between the register-write decode (reload values) and the tone/output logic (borrow pulses) of the audio channel block.

## Interface

Parameters:
- WIDTH, 8, bits per channel; the joined counter is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst  input  1  synchronous active-high reset; sampled on the falling clk edge; independent of enn.
- enn  input  1  clock enable; qualifies every non-reset update.
- din  input  WIDTH  reload write data.
- wr0  input  1  write din into reload register 0.
- wr1  input  1  write din into reload register 1.
- tick0  input  1  count strobe, channel 0; also the joined counter's strobe.
- tick1  input  1  count strobe, channel 1; ignored while join=1.
- join  input  1  1 = cascade; channel 0 is the low half, channel 1 the high half.
- stimer  input  1  force-load both counters from their reload registers.
- cnt0  output  WIDTH  channel 0 counter value.
- cnt1  output  WIDTH  channel 1 counter value.
- bor0  output  1  registered borrow pulse, channel 0.
- bor1  output  1  registered borrow pulse, channel 1 or the joined counter.

## Operation

- Reset: rst=1 on a falling edge clears reload0, reload1, cnt0, cnt1, bor0 and bor1 to 0. Reset wins over every other input, including mid-count and mid-write.
- No state changes on an edge with enn=0 and rst=0; borrow outputs hold their value.
- Writes: wr0 latches din into reload0 and wr1 into reload1. wr0 and wr1 may be asserted on the same edge, and both then latch din.
- Independent mode (join=0), per channel i, on each enabled edge:
  - stimer=1: cnt_i <= reload_i; bor_i <= 0.
  - else tick_i=1 and cnt_i==0: cnt_i <= reload_i; bor_i <= 1.
  - else tick_i=1: cnt_i <= cnt_i-1; bor_i <= 0.
  - else bor_i <= 0.
- Joined mode (join=1), with C = {cnt1,cnt0} and R = {reload1,reload0}, on each enabled edge:
  - stimer=1: C <= R.
  - else tick0=1 and C==0: C <= R; bor1 <= 1.
  - else tick0=1: C <= C-1 (full 2*WIDTH-bit decrement; borrow crosses the halves).
  - bor0 is forced to 0 and tick1 is ignored.
- Period: reload value R yields one borrow every R+1 ticks. R=0 yields a borrow on every tick.
- Arithmetic is unsigned modulo the counter width. There is no wrap below 0, because the zero state always reloads.
- A write and a load on the same edge (stimer, or a zero-reload): the counter loads the old reload value, and the new value is used from the next load onward.
- Changing join takes effect on the next enabled edge. The counters keep their current values and are not reloaded; software issues stimer after a mode change.
- stimer together with a tick: stimer wins, and no borrow is generated.

## Timing

- Single clock domain. Every register updates on the falling edge of clk.
- Latency:
  - reload registers update 1 enabled edge after the write;
  - cnt changes 1 enabled edge after the tick or stimer;
  - bor is high for exactly one enabled edge, following the edge that sampled the terminal tick.
- bor* are registered; cnt* are direct register outputs. No output has a combinational path from any input.
- Reset value of every output: cnt0=0, cnt1=0, bor0=0, bor1=0.

## Test plan

- Reset then idle: after rst, assert tick0/tick1 with reload=0 -> bor0 and bor1 are high on every enabled edge while ticking, and cnt stays 0.
- Independent count: WIDTH=8; wr0 din=3; stimer; tick0 every edge -> cnt0 goes 3,2,1,0,3; bor0 is high only on the edge that reloads, giving a period of 4; channel 1 is unaffected.
- Joined count: reload1=0x01, reload0=0x02; join=1; stimer; tick0 continuous -> C goes 0x0102, 0x0101, 0x0100, 0x00FF … 0x0000, then reloads 0x0102; bor1 pulses once every 259 ticks; bor0 stays 0; toggling tick1 has no effect.
- Enable gating: drive tick0 with enn alternating 1/0 -> the count advances only on enn=1 edges; bor0 holds its level during enn=0 edges.
- Simultaneous events: write reload0=5 on the same edge as stimer while reload0 was 2 -> cnt0=2; the next zero-reload loads 5. stimer plus tick on a zero count -> load occurs and there is no borrow.
- Reset mid-operation: assert rst while counting joined with reload 0xFFFF, with enn=0 -> all registers and outputs are 0 on that edge; join remains an input-only setting.
